// File: rtl/conversor_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit width, default sizes and counter width helper.
package conversor_bcd_seq_pkg;

  typedef enum logic {
    OCIOSO  = 1'b0,
    DESLOCA = 1'b1
  } estado_t;

  localparam int DIGITO_W      = 4;
  localparam int N_BITS_DEF    = 8;
  localparam int N_DIGITOS_DEF = 3;

  // Counter must hold 0..n, so it needs clog2(n+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conversor_bcd_seq_ajuste_add3.sv
// One BCD digit correction step: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module conversor_bcd_seq_ajuste_add3
  import conversor_bcd_seq_pkg::*;
(
  input  logic [DIGITO_W-1:0] d_i,
  output logic [DIGITO_W-1:0] d_o
);

  assign d_o = (d_i >= DIGITO_W'(5)) ? d_i + DIGITO_W'(3) : d_i;

endmodule

// File: rtl/conversor_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Output digits update only at completion, so the display never sees partial values.
module conversor_bcd_seq
  import conversor_bcd_seq_pkg::*;
#(
  parameter int N_BITS    = N_BITS_DEF,
  parameter int N_DIGITOS = N_DIGITOS_DEF
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [N_BITS-1:0]   Entrada,
  input  logic                Iniciar,
  input  logic                Auto,
  output logic                Ocupado,
  output logic                Pronto,
  output logic                Valido,
  output logic [DIGITO_W-1:0] Centena,
  output logic [DIGITO_W-1:0] Dezena,
  output logic [DIGITO_W-1:0] Unidade,
  output estado_t             estado_o
);

  localparam int ACC_W = DIGITO_W * N_DIGITOS;
  localparam int CNT_W = cnt_width(N_BITS);
  localparam int DIG_W = 3 * DIGITO_W;

  // Handshake: a start is accepted only in OCIOSO (Ocupado=0); Pronto pulses
  // for one cycle when Centena/Dezena/Unidade take the new result.
  estado_t             estado_q, estado_d;
  logic [N_BITS-1:0]   desl_q, desl_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   ultimo_q, ultimo_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic                pronto_q, pronto_d;
  logic                valido_q, valido_d;

  logic [ACC_W-1:0]        acc_aj;
  logic [ACC_W+N_BITS-1:0] desloc;
  logic                    inicio;

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ajuste
    conversor_bcd_seq_ajuste_add3 u_ajuste_add3 (
      .d_i (acc_q[g*DIGITO_W +: DIGITO_W]),
      .d_o (acc_aj[g*DIGITO_W +: DIGITO_W])
    );
  end

  assign desloc = {acc_aj, desl_q} << 1;
  assign inicio = Iniciar | (Auto & (Entrada != ultimo_q));

  always_comb begin
    estado_d = estado_q;
    desl_d   = desl_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ultimo_d = ultimo_q;
    dig_d    = dig_q;
    pronto_d = 1'b0;
    valido_d = valido_q;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          desl_d   = Entrada;
          ultimo_d = Entrada;
          acc_d    = '0;
          cnt_d    = '0;
          estado_d = DESLOCA;
        end
      end
      DESLOCA: begin
        acc_d  = desloc[ACC_W+N_BITS-1:N_BITS];
        desl_d = desloc[N_BITS-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          // Last shift: publish the corrected-and-shifted accumulator directly.
          dig_d    = desloc[N_BITS +: DIG_W];
          pronto_d = 1'b1;
          valido_d = 1'b1;
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q <= OCIOSO;
      desl_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ultimo_q <= '0;
      dig_q    <= '0;
      pronto_q <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      desl_q   <= desl_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ultimo_q <= ultimo_d;
      dig_q    <= dig_d;
      pronto_q <= pronto_d;
      valido_q <= valido_d;
    end
  end

  assign Ocupado  = (estado_q == DESLOCA);
  assign Pronto   = pronto_q;
  assign Valido   = valido_q;
  assign Centena  = dig_q[2*DIGITO_W +: DIGITO_W];
  assign Dezena   = dig_q[DIGITO_W +: DIGITO_W];
  assign Unidade  = dig_q[0 +: DIGITO_W];
  assign estado_o = estado_q;

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Bench for conversor_bcd_seq: directed scenarios plus random and sweep
// stimulus, checked by a Pronto-driven monitor against a decimal model.
module tb_conversor_bcd_seq;
  import conversor_bcd_seq_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Entrada = '0;
  logic       Iniciar = 1'b0;
  logic       Auto = 1'b0;
  logic       Ocupado, Pronto, Valido;
  logic [3:0] Centena, Dezena, Unidade;
  estado_t    estado_o;

  conversor_bcd_seq dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Entrada  (Entrada),
    .Iniciar  (Iniciar),
    .Auto     (Auto),
    .Ocupado  (Ocupado),
    .Pronto   (Pronto),
    .Valido   (Valido),
    .Centena  (Centena),
    .Dezena   (Dezena),
    .Unidade  (Unidade),
    .estado_o (estado_o)
  );

  // clock / cycle count
  always #5 Clock = ~Clock;
  int cyc = 0;
  always @(posedge Clock) cyc++;

  // scoreboard state
  logic [11:0] exp_q[$];
  int          lat_q[$];
  logic [11:0] last_exp = '0;
  logic [7:0]  ultimo_m = '0;
  int          checks = 0;
  int          errors = 0;
  int          pushed_cnt = 0;
  int          pronto_cnt = 0;
  int          run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(ref_bcd(int'(v)));
    lat_q.push_back(cyc + 9);
    ultimo_m = v;
    pushed_cnt++;
  endtask

  // monitor
  always @(negedge Clock) begin
    if (!Reset_n) begin
      run = 0;
    end else begin
      if (Pronto) begin
        pronto_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pronto", 1, 0);
        end else begin
          logic [11:0] e;
          int          c;
          e = exp_q.pop_front();
          c = lat_q.pop_front();
          chk("digits", {Centena, Dezena, Unidade}, e);
          chk("pronto_latency", cyc, c);
          chk("valido_on_pronto", Valido, 1);
          last_exp = e;
        end
      end else begin
        chk("digits_hold", {Centena, Dezena, Unidade}, last_exp);
      end
      if (Ocupado) run++;
      else if (run != 0) begin
        chk("ocupado_run", run, 8);
        run = 0;
      end
    end
  end

  // drivers
  task automatic wait_idle();
    int n = 0;
    while (Ocupado && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) chk("idle_timeout", n, 0);
  endtask

  task automatic issue(input logic [7:0] v, input bit via_auto, output bit started);
    wait_idle();
    Entrada = v;
    started = 1'b0;
    if (via_auto) begin
      Auto = 1'b1;
      if (v != ultimo_m) begin
        push_exp(v);
        started = 1'b1;
      end
    end else begin
      Iniciar = 1'b1;
      push_exp(v);
      started = 1'b1;
    end
    @(negedge Clock);
    Iniciar = 1'b0;
  endtask

  initial begin
    bit st;
    int p0;
    logic [7:0] v;

    // reset state
    repeat (2) @(negedge Clock);
    chk("rst_ocupado", Ocupado, 0);
    chk("rst_pronto", Pronto, 0);
    chk("rst_valido", Valido, 0);
    chk("rst_digits", {Centena, Dezena, Unidade}, 0);
    chk("rst_estado", estado_o, OCIOSO);
    Reset_n = 1'b1;
    @(negedge Clock);

    // 255 by Iniciar
    issue(8'd255, 1'b0, st);
    chk("busy_ocupado", Ocupado, 1);
    chk("busy_estado", estado_o, DESLOCA);
    wait_idle();
    chk("valido_sticky", Valido, 1);

    // back-to-back on the Pronto cycle
    issue(8'd0, 1'b0, st);
    issue(8'd128, 1'b0, st);
    issue(8'd9, 1'b0, st);
    wait_idle();
    @(negedge Clock);

    // inputs ignored while busy
    issue(8'd42, 1'b0, st);
    repeat (2) @(negedge Clock);
    Entrada = 8'd99;
    Iniciar = 1'b1;
    @(negedge Clock);
    Iniciar = 1'b0;
    wait_idle();
    repeat (3) @(negedge Clock);
    chk("no_extra_conv", pronto_cnt, pushed_cnt);

    // Auto restart, then no retrigger with stable input
    issue(8'd99, 1'b1, st);
    wait_idle();
    p0 = pronto_cnt;
    repeat (50) @(negedge Clock);
    chk("auto_stable_pronto", pronto_cnt - p0, 1);
    chk("auto_no_retrigger", pronto_cnt, pushed_cnt);
    Auto = 1'b0;

    // reset mid-conversion
    issue(8'd200, 1'b0, st);
    repeat (3) @(negedge Clock);
    #1;
    Reset_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    pushed_cnt--;
    last_exp = '0;
    ultimo_m = '0;
    @(negedge Clock);
    chk("abort_ocupado", Ocupado, 0);
    chk("abort_pronto", Pronto, 0);
    chk("abort_valido", Valido, 0);
    chk("abort_digits", {Centena, Dezena, Unidade}, 0);
    #1;
    Reset_n = 1'b1;
    @(negedge Clock);
    issue(8'd200, 1'b0, st);
    wait_idle();

    // random mix with noise on the inputs while busy
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      issue(v, bit'($urandom_range(0, 1)), st);
      if (st) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge Clock);
          Iniciar = 1'($urandom_range(0, 1));
          Entrada = 8'($urandom);
        end
        @(negedge Clock);
        Iniciar = 1'b0;
        Entrada = v;
      end
    end
    wait_idle();
    Auto = 1'b0;
    @(negedge Clock);

    // sweep with Auto
    for (int i = 0; i < 256; i++) issue(8'(i), 1'b1, st);
    wait_idle();
    repeat (12) @(negedge Clock);

    chk("queue_drained", exp_q.size(), 0);
    chk("pronto_count", pronto_cnt, pushed_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conversor_bcd_seq.md
Name: conversor_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the 8-bit ALU result.
- Sits directly upstream of the display stage. Its Centena/Dezena/Unidade digits feed the decimal 7-segment decoders, which fills the decimal path that is currently tied to zero.
- Holds the last converted digits stable while a new conversion runs, so the display never shows partial values.

Parameters:
- N_BITS, 8, width of the binary input; number of shift cycles per conversion.
- N_DIGITOS, 3, number of BCD output digits; must satisfy 10^N_DIGITOS > 2^N_BITS - 1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous reset, active low.
- Entrada  input  N_BITS  unsigned binary value (ALU Resultado).
- Iniciar  input  1  start request, sampled only in OCIOSO.
- Auto  input  1  1 = restart automatically whenever Entrada differs from the last converted value.
- Ocupado  output  1  conversion in progress.
- Pronto  output  1  one-cycle pulse when new digits are written.
- Valido  output  1  at least one conversion has completed since reset.
- Centena  output  4  BCD hundreds digit (0..2 for N_BITS=8).
- Dezena  output  4  BCD tens digit.
- Unidade  output  4  BCD units digit.

Behaviour:
- Reset (Reset_n=0, asynchronous): state OCIOSO; Ocupado=0, Pronto=0, Valido=0; digits=0; shift register, counter and last-converted register=0.
- States:
  - OCIOSO: waits for a start condition.
  - DESLOCA: iterates the conversion.
- Start condition in OCIOSO: Iniciar=1, or (Auto=1 and Entrada != UltimoConvertido). Both at once count as one start.
- At the start edge k:
  - capture Entrada into the shift register and into UltimoConvertido;
  - clear the BCD accumulator and counter;
  - go to DESLOCA; Ocupado=1 from the cycle after edge k.
- Each edge in DESLOCA:
  - every accumulator digit >= 5 gets +3 (combinational, all digits in parallel);
  - then {accumulator, shift register} shifts left by 1;
  - counter increments.
- Edge k+N_BITS (last shift): write the final accumulator to Centena/Dezena/Unidade; Pronto=1 for exactly one cycle; Valido=1 (sticky until reset); Ocupado=0; return to OCIOSO.
- Latency: N_BITS cycles from the start edge to the cycle in which Pronto is high (8 for the default).
- Outputs change only at the completion edge; intermediate accumulator values are never visible.
- Iniciar or Entrada changes while Ocupado=1: ignored. The captured value is converted.
- Back-to-back: a start condition in the cycle where Pronto=1 (state already OCIOSO) is accepted, giving one conversion per N_BITS+1 cycles maximum.
- Auto=1 with Entrada stable after completion: no retrigger (Entrada equals UltimoConvertido).
- Reset asserted mid-conversion: immediate abort to reset values; no Pronto pulse.
- Counter width: clog2(N_BITS+1). No wrap, because the counter terminates at N_BITS.
- The accumulator is 4*N_DIGITOS bits. The add-3 before shift guarantees each digit stays in 0..9; no overflow for legal parameters.

Decomposition:
- Shared package:
  - state encoding (OCIOSO, DESLOCA);
  - BCD digit width constant (4);
  - N_BITS/N_DIGITOS defaults;
  - function computing counter width.
- Sub-module ajuste_add3:
  - combinational, 4-bit in / 4-bit out, output = in + 3 if in >= 5, else in;
  - instantiated N_DIGITOS times in a generate loop.
- FSM, counter and registers stay in the top.

Test Plan:
- Entrada=255, Iniciar pulse -> Ocupado high 8 cycles; Pronto one cycle; digits 2,5,5; Valido=1.
- Entrada=0, then 128, then 9, each started on the Pronto cycle of the previous -> digits 0,0,0 / 1,2,8 / 0,0,9; each Pronto exactly 9 cycles after the previous one.
- Entrada=42 started; Entrada changed to 99 and Iniciar re-pulsed at cycle 3 -> result 0,4,2; no extra conversion; digits stay at prior value until completion.
- Auto=1, Entrada 42 -> 99 while idle -> conversion starts without Iniciar; digits 0,9,9. Entrada held at 99 -> no further Pronto over 50 cycles.
- Reset_n pulsed low at cycle 4 of converting 200 -> all outputs 0, Valido=0, no Pronto. A new start with 200 -> 2,0,0.
- Exhaustive sweep 0..255 with Auto=1 -> every result matches the reference decimal digits; Ocupado never high for more than 8 consecutive cycles.
